nd_2to1: RTL and testbench
==========================

# nd_2to1

Two-input merge node for the messaging network. It accepts messages on two independent 4-phase request/acknowledge input channels (`rcv0`, `rcv1`) and buffers them in one shared FIFO. It forwards them unmodified on a single output channel (`snd0`). Round-robin arbitration resolves contention between the two inputs. It is the upstream companion of the `nd_1to2` splitter and recombines traffic before it enters a splitter or a sink.

## Interface
- `FSZ`, default `NS_1to2_FSZ`: log2 of FIFO depth; depth = 2**FSZ entries.
- `ASZ`, default `NS_ADDRESS_SIZE`: width of `src` and `dst`.
- `DSZ`, default `NS_DATA_SIZE`: width of `dat`.
- `RSZ`, default `NS_REDUN_SIZE`: width of `red`.

Ports:
- `i_clk`  in  1  sole clock; all logic on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `ready`  out  1  node initialised and operating.
- `snd0_src`/`snd0_dst`/`snd0_dat`/`snd0_red`  out  ASZ/ASZ/DSZ/RSZ  outgoing message.
- `snd0_req`  out  1  output request.
- `snd0_ack`  in  1  output acknowledge.
- `rcv0_src`/`rcv0_dst`/`rcv0_dat`/`rcv0_red`  in  ASZ/ASZ/DSZ/RSZ  input 0 message.
- `rcv0_req`  in  1;  `rcv0_ack`  out  1.
- `rcv1_*`: same as `rcv0_*`, for input 1.
- `dbg_leds`  out  4;  `dbg_disp0`  out  4;  `dbg_disp1`  out  4.  Debug channel.

## Operation
- **Reset:** while `reset`=1, every output is 0 at the next edge, the FIFO is emptied and the arbiter pointer is set to input 0. In-flight messages are discarded. On the first cycle with `reset`=0, `ready` goes to 1 at that edge. Inputs are ignored until `ready`=1.
- **Handshake (both directions), 4-phase:**
  1. The sender raises `req` with the message already stable.
  2. The receiver captures the message and raises `ack`.
  3. The sender drops `req`.
  4. The receiver drops `ack`.
- **Input eligibility:** input X is eligible when `rcvX_req`=1, `rcvX_ack`=0 and the FIFO is not full.
- **Arbitration:**
  - At most one input is written per cycle.
  - If only one input is eligible, it is granted.
  - If both are eligible, the input selected by the priority pointer is granted and the pointer moves to the other input.
  - The pointer changes only on contended grants.
- **Input accept:** the granted message (src, dst, dat, red) is written to the FIFO tail and `rcvX_ack` is set to 1. `rcvX_ack` clears on the first edge at which `rcvX_req`=0.
- **Output FSM, states IDLE → SEND → WAIT_LOW → IDLE:**
  - IDLE: if the FIFO is not empty, load the head into the output registers, set `snd0_req`=1 and go to SEND.
  - SEND: on `snd0_ack`=1, clear `snd0_req`, pop the head and go to WAIT_LOW.
  - WAIT_LOW: on `snd0_ack`=0, go to IDLE.
- **Output hold:** output data registers hold their value from load until the next load.
- **Push and pop in the same cycle** are both performed; the occupancy count is unchanged.
- **Full FIFO** (count = 2**FSZ): neither input is acknowledged; requests wait and no data is lost. Pointers wrap modulo 2**FSZ. The count is FSZ+1 bits wide.
- **Debug outputs** (sticky until reset):
  - `dbg_leds[0]` is set when the FIFO has been full.
  - `dbg_leds[1]` is set when an input contention has occurred.
  - `dbg_leds[3:2]` are 0.
  - `dbg_disp0` holds the low 4 bits of a forwarded-message counter that increments on each pop and wraps at 16.
  - `dbg_disp1` holds the low 4 bits of `snd0_src` of the last loaded message.
- **Message integrity:** the message is not modified; `red` is passed through unchecked.

## Timing
- **Input req to ack:** `rcvX_req` rising, sampled at edge N (eligible and granted), gives `rcvX_ack`=1 after edge N. Minimum latency is 1 cycle.
- **Input to output:** a write at edge N makes the FIFO non-empty; the load at edge N+1 sets `snd0_req`=1 after N+1. Minimum req-to-req latency is 2 cycles.
- **Output ack to req drop:** `snd0_ack`=1 sampled at edge M gives `snd0_req`=0 and a pop at edge M.
- **Next output request:** the earliest next `snd0_req` comes 1 cycle after `snd0_ack` is sampled low.
- **Throughput:** one message per 4-phase output cycle, at most 1 per 3 clocks with a zero-latency consumer.
- **Output order:** FIFO order, which equals grant order.
- **Fairness:** with both inputs continuously requesting, grants strictly alternate 0,1,0,1…

## Test plan
- Reset held 3 cycles, then released. Required: all outputs 0 during reset; `ready`=1 one edge after release; `snd0_req` stays 0.
- Single message on `rcv0` (src=1, dst=5, dat=9), consumer acks immediately. Required: `rcv0_ack` 1 cycle after req; `snd0_req` 2 cycles after req with src=1, dst=5, dat=9; `dbg_disp0`=1.
- Both inputs present a message on the same cycle, repeated for 4 messages each (rcv0 dat=0..3, rcv1 dat=8..11). Required: output dat order is 0,8,1,9,2,10,3,11; `dbg_leds[1]`=1.
- `snd0_ack` held 0 while `rcv0` sends 2**FSZ+1 messages. Required: exactly 2**FSZ acks, the last request stays unacked, `dbg_leds[0]`=1. Then release ack: all 2**FSZ+1 messages are delivered in order.
- `reset` asserted while `snd0_req`=1 and the FIFO holds 2 messages. Required: the next edge gives `snd0_req`=0, `rcv*_ack`=0, FIFO empty, `ready`=0. After release, no stale message is emitted.
- Sender holds `rcv1_req` high for 5 cycles after ack. Required: no second write occurs; `rcv1_ack` drops on the edge after `rcv1_req` goes low.

Source files
------------

// File: rtl/nd_2to1_if.sv
// Message channel of the messaging network: payload (src, dst, dat, red)
// plus a 4-phase req/ack pair. The master drives the payload and req.
`ifndef NS_ADDRESS_SIZE
`define NS_ADDRESS_SIZE 8
`endif
`ifndef NS_DATA_SIZE
`define NS_DATA_SIZE 16
`endif
`ifndef NS_REDUN_SIZE
`define NS_REDUN_SIZE 4
`endif

interface nd_2to1_if #(
    parameter int ASZ = `NS_ADDRESS_SIZE,
    parameter int DSZ = `NS_DATA_SIZE,
    parameter int RSZ = `NS_REDUN_SIZE
);
    logic [ASZ-1:0] src;
    logic [ASZ-1:0] dst;
    logic [DSZ-1:0] dat;
    logic [RSZ-1:0] red;
    logic           req;
    logic           ack;

    modport master (output src, dst, dat, red, req, input ack);
    modport slave  (input src, dst, dat, red, req, output ack);
endinterface

// File: rtl/nd_2to1.sv
// Two-input merge node: round-robin arbitration of two 4-phase input
// channels into one shared FIFO, drained by a 4-phase output sender.
`ifndef NS_1to2_FSZ
`define NS_1to2_FSZ 2
`endif
`ifndef NS_ADDRESS_SIZE
`define NS_ADDRESS_SIZE 8
`endif
`ifndef NS_DATA_SIZE
`define NS_DATA_SIZE 16
`endif
`ifndef NS_REDUN_SIZE
`define NS_REDUN_SIZE 4
`endif

module nd_2to1 #(
    parameter int FSZ = `NS_1to2_FSZ,
    parameter int ASZ = `NS_ADDRESS_SIZE,
    parameter int DSZ = `NS_DATA_SIZE,
    parameter int RSZ = `NS_REDUN_SIZE
) (
    input  logic       i_clk,
    input  logic       reset,
    output logic       ready,
    nd_2to1_if.master  snd0,
    nd_2to1_if.slave   rcv0,
    nd_2to1_if.slave   rcv1,
    output logic [3:0] dbg_leds,
    output logic [3:0] dbg_disp0,
    output logic [3:0] dbg_disp1
);
    localparam int             DEPTH    = 2 ** FSZ;
    localparam int             MSZ      = 2 * ASZ + DSZ + RSZ;
    localparam logic [FSZ:0]   FULL_CNT = (FSZ + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, WAIT_LOW = 2'd2} state_t;

    function automatic logic [3:0] low_nibble(input logic [ASZ-1:0] v);
        logic [ASZ+3:0] ext;
        ext = {4'b0000, v};
        return ext[3:0];
    endfunction

    logic [MSZ-1:0] fifo_mem [DEPTH];

    state_t         state_q, state_d;
    logic           ready_q, ready_d;
    logic           ptr_q, ptr_d;
    logic [FSZ-1:0] wr_ptr_q, wr_ptr_d;
    logic [FSZ-1:0] rd_ptr_q, rd_ptr_d;
    logic [FSZ:0]   count_q, count_d;
    logic           ack0_q, ack0_d;
    logic           ack1_q, ack1_d;
    logic [MSZ-1:0] snd_msg_q, snd_msg_d;
    logic           snd_req_q, snd_req_d;
    logic           full_seen_q, full_seen_d;
    logic           cont_seen_q, cont_seen_d;
    logic [3:0]     fwd_cnt_q, fwd_cnt_d;
    logic [3:0]     disp1_q, disp1_d;

    logic           full, elig0, elig1, grant0, grant1, push, pop;
    logic [MSZ-1:0] wr_msg, head;

    always_comb begin
        ready_d     = 1'b1;
        full        = (count_q == FULL_CNT);
        elig0       = ready_q && rcv0.req && !ack0_q && !full;
        elig1       = ready_q && rcv1.req && !ack1_q && !full;
        // Pointer names the favoured input and only moves on a contended grant.
        grant0      = elig0 && (!elig1 || !ptr_q);
        grant1      = elig1 && (!elig0 || ptr_q);
        ptr_d       = (elig0 && elig1) ? ~ptr_q : ptr_q;
        push        = grant0 || grant1;
        wr_msg      = grant0 ? {rcv0.src, rcv0.dst, rcv0.dat, rcv0.red}
                             : {rcv1.src, rcv1.dst, rcv1.dat, rcv1.red};
        ack0_d      = grant0 ? 1'b1 : (rcv0.req ? ack0_q : 1'b0);
        ack1_d      = grant1 ? 1'b1 : (rcv1.req ? ack1_q : 1'b0);
        full_seen_d = full_seen_q || full;
        cont_seen_d = cont_seen_q || (elig0 && elig1);

        head        = fifo_mem[rd_ptr_q];
        state_d     = state_q;
        snd_msg_d   = snd_msg_q;
        snd_req_d   = snd_req_q;
        disp1_d     = disp1_q;
        pop         = 1'b0;
        case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    snd_msg_d = head;
                    snd_req_d = 1'b1;
                    disp1_d   = low_nibble(head[MSZ-1 -: ASZ]);
                    state_d   = SEND;
                end
            end
            SEND: begin
                if (snd0.ack) begin
                    snd_req_d = 1'b0;
                    pop       = 1'b1;
                    state_d   = WAIT_LOW;
                end
            end
            WAIT_LOW: begin
                if (!snd0.ack) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        wr_ptr_d  = push ? wr_ptr_q + FSZ'(1) : wr_ptr_q;
        rd_ptr_d  = pop ? rd_ptr_q + FSZ'(1) : rd_ptr_q;
        fwd_cnt_d = pop ? fwd_cnt_q + 4'd1 : fwd_cnt_q;
        case ({push, pop})
            2'b10:   count_d = count_q + (FSZ + 1)'(1);
            2'b01:   count_d = count_q - (FSZ + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Payload storage carries no reset; occupancy is governed by the pointers.
    always_ff @(posedge i_clk) begin
        if (push) fifo_mem[wr_ptr_q] <= wr_msg;
    end

    always_ff @(posedge i_clk) begin
        if (reset) begin
            state_q     <= IDLE;
            ready_q     <= 1'b0;
            ptr_q       <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            ack0_q      <= 1'b0;
            ack1_q      <= 1'b0;
            snd_msg_q   <= '0;
            snd_req_q   <= 1'b0;
            full_seen_q <= 1'b0;
            cont_seen_q <= 1'b0;
            fwd_cnt_q   <= 4'd0;
            disp1_q     <= 4'd0;
        end else begin
            state_q     <= state_d;
            ready_q     <= ready_d;
            ptr_q       <= ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            ack0_q      <= ack0_d;
            ack1_q      <= ack1_d;
            snd_msg_q   <= snd_msg_d;
            snd_req_q   <= snd_req_d;
            full_seen_q <= full_seen_d;
            cont_seen_q <= cont_seen_d;
            fwd_cnt_q   <= fwd_cnt_d;
            disp1_q     <= disp1_d;
        end
    end

    assign ready     = ready_q;
    assign rcv0.ack  = ack0_q;
    assign rcv1.ack  = ack1_q;
    assign snd0.req  = snd_req_q;
    assign snd0.src  = snd_msg_q[MSZ-1 -: ASZ];
    assign snd0.dst  = snd_msg_q[MSZ-ASZ-1 -: ASZ];
    assign snd0.dat  = snd_msg_q[RSZ +: DSZ];
    assign snd0.red  = snd_msg_q[RSZ-1:0];
    assign dbg_leds  = {2'b00, cont_seen_q, full_seen_q};
    assign dbg_disp0 = fwd_cnt_q;
    assign dbg_disp1 = disp1_q;
endmodule

// File: tb/tb_nd_2to1.sv
// Directed bench for nd_2to1: two input senders, a 4-phase sink and a
// scoreboard queue of messages expected on snd0 in delivery order.
`timescale 1ns/1ps
module tb_nd_2to1;
    localparam int FSZ = 2;
    localparam int ASZ = 8;
    localparam int DSZ = 16;
    localparam int RSZ = 4;
    localparam int DEPTH = 2 ** FSZ;

    typedef struct packed {
        logic [ASZ-1:0] src;
        logic [ASZ-1:0] dst;
        logic [DSZ-1:0] dat;
        logic [RSZ-1:0] red;
    } msg_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ready;
    logic [3:0] dbg_leds, dbg_disp0, dbg_disp1;

    nd_2to1_if #(.ASZ(ASZ), .DSZ(DSZ), .RSZ(RSZ)) snd0 ();
    nd_2to1_if #(.ASZ(ASZ), .DSZ(DSZ), .RSZ(RSZ)) rcv0 ();
    nd_2to1_if #(.ASZ(ASZ), .DSZ(DSZ), .RSZ(RSZ)) rcv1 ();

    nd_2to1 #(.FSZ(FSZ), .ASZ(ASZ), .DSZ(DSZ), .RSZ(RSZ)) dut (
        .i_clk(clk), .reset(reset), .ready(ready),
        .snd0(snd0), .rcv0(rcv0), .rcv1(rcv1),
        .dbg_leds(dbg_leds), .dbg_disp0(dbg_disp0), .dbg_disp1(dbg_disp1)
    );

    always #5 clk = ~clk;

    msg_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    bit   ack_en = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic msg_t mk(input int s, input int d, input int t, input int r);
        msg_t m;
        m.src = ASZ'(s);
        m.dst = ASZ'(d);
        m.dat = DSZ'(t);
        m.red = RSZ'(r);
        return m;
    endfunction

    function automatic logic [63:0] outs_vec();
        return 64'({ready, snd0.req, rcv0.ack, rcv1.ack, dbg_leds, dbg_disp0, dbg_disp1,
                    snd0.src, snd0.dst, snd0.dat, snd0.red});
    endfunction

    function automatic logic get_ack(input int ch);
        return (ch == 0) ? rcv0.ack : rcv1.ack;
    endfunction

    task automatic drive(input int ch, input msg_t m, input logic r);
        if (ch == 0) begin
            {rcv0.src, rcv0.dst, rcv0.dat, rcv0.red} = m;
            rcv0.req = r;
        end else begin
            {rcv1.src, rcv1.dst, rcv1.dat, rcv1.red} = m;
            rcv1.req = r;
        end
    endtask

    // Full 4-phase send; leaves req high if no ack arrives within max_wait.
    task automatic send(input int ch, input msg_t m, input int max_wait, output bit acked);
        acked = 1'b0;
        drive(ch, m, 1'b1);
        for (int i = 0; i < max_wait; i++) begin
            step();
            if (get_ack(ch)) begin
                acked = 1'b1;
                break;
            end
        end
        if (acked) begin
            drive(ch, m, 1'b0);
            for (int i = 0; i < 8 && get_ack(ch); i++) step();
        end
    endtask

    task automatic wait_drain(input int max_cycles);
        for (int i = 0; i < max_cycles; i++) begin
            if (exp_q.size() == 0 && !snd0.req) break;
            step();
        end
        chk("drain_left", 64'(exp_q.size()), 64'd0);
        step(3);
    endtask

    // Output sink: checks each newly presented message against the scoreboard.
    initial begin : consumer
        bit   seen;
        msg_t got, expm;
        seen = 1'b0;
        snd0.ack = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (snd0.req && !seen) begin
                seen = 1'b1;
                got = {snd0.src, snd0.dst, snd0.dat, snd0.red};
                if (exp_q.size() == 0) begin
                    chk("sb_unexpected_msg", 64'(got), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    expm = exp_q.pop_front();
                    chk("sb_msg", 64'(got), 64'(expm));
                end
            end
            if (!snd0.req) begin
                seen = 1'b0;
                snd0.ack = 1'b0;
            end else if (seen && ack_en) begin
                snd0.ack = 1'b1;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

    initial begin : stim
        bit   a;
        int   n_acks;
        bit   flag;
        msg_t m;

        drive(0, mk(0, 0, 0, 0), 1'b0);
        drive(1, mk(0, 0, 0, 0), 1'b0);
        reset = 1'b1;

        for (int i = 0; i < 3; i++) begin
            step();
            chk("reset_outputs", outs_vec(), 64'd0);
        end
        reset = 1'b0;
        step();
        chk("ready_after_release", 64'(ready), 64'd1);
        chk("snd_req_idle", 64'(snd0.req), 64'd0);

        // Single message with immediate consumer.
        ack_en = 1'b1;
        m = mk(1, 5, 9, 0);
        exp_q.push_back(m);
        drive(0, m, 1'b1);
        step();
        chk("rcv0_ack_lat1", 64'(rcv0.ack), 64'd1);
        chk("snd_req_not_yet", 64'(snd0.req), 64'd0);
        drive(0, m, 1'b0);
        step();
        chk("snd_req_lat2", 64'(snd0.req), 64'd1);
        chk("snd_msg_lat2", 64'({snd0.src, snd0.dst, snd0.dat}), 64'({8'd1, 8'd5, 16'd9}));
        chk("rcv0_ack_clear", 64'(rcv0.ack), 64'd0);
        wait_drain(50);
        chk("disp0_one", 64'(dbg_disp0), 64'd1);
        chk("disp1_src", 64'(dbg_disp1), 64'd1);

        // Simultaneous senders: expect strict alternation starting at input 0.
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back(mk(0, 4, k, 1));
            exp_q.push_back(mk(1, 4, 8 + k, 2));
        end
        fork
            begin
                automatic bit a0;
                for (int k = 0; k < 4; k++) begin
                    send(0, mk(0, 4, k, 1), 40, a0);
                    chk("contend_ack0", 64'(a0), 64'd1);
                end
            end
            begin
                automatic bit a1;
                for (int k = 0; k < 4; k++) begin
                    send(1, mk(1, 4, 8 + k, 2), 40, a1);
                    chk("contend_ack1", 64'(a1), 64'd1);
                end
            end
        join
        wait_drain(200);
        chk("dbg_contention", 64'(dbg_leds[1]), 64'd1);

        // Stalled consumer: FIFO fills, extra request waits.
        ack_en = 1'b0;
        n_acks = 0;
        for (int k = 0; k < DEPTH; k++) begin
            m = mk(2, 3, 100 + k, k);
            exp_q.push_back(m);
            send(0, m, 20, a);
            if (a) n_acks++;
        end
        chk("full_ack_count", 64'(n_acks), 64'(DEPTH));
        m = mk(2, 3, 100 + DEPTH, 7);
        exp_q.push_back(m);
        drive(0, m, 1'b1);
        step(10);
        chk("full_no_ack", 64'(rcv0.ack), 64'd0);
        chk("dbg_full", 64'(dbg_leds[0]), 64'd1);
        chk("full_head_presented", 64'(snd0.req), 64'd1);
        ack_en = 1'b1;
        for (int i = 0; i < 40 && !rcv0.ack; i++) step();
        chk("full_late_ack", 64'(rcv0.ack), 64'd1);
        drive(0, m, 1'b0);
        step();
        wait_drain(200);

        // Reset while a message is presented and another is queued.
        ack_en = 1'b0;
        m = mk(9, 1, 16'h0A0A, 5);
        exp_q.push_back(m);
        send(0, m, 20, a);
        chk("rst_msgA_ack", 64'(a), 64'd1);
        send(0, mk(9, 2, 16'h0B0B, 6), 20, a);
        chk("rst_msgB_ack", 64'(a), 64'd1);
        for (int i = 0; i < 10 && !snd0.req; i++) step();
        chk("rst_req_before", 64'(snd0.req), 64'd1);
        reset = 1'b1;
        step();
        chk("rst_mid_outputs", outs_vec(), 64'd0);
        reset = 1'b0;
        ack_en = 1'b1;
        step();
        chk("rst_mid_ready", 64'(ready), 64'd1);
        flag = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (snd0.req) flag = 1'b1;
        end
        chk("rst_no_stale", 64'(flag), 64'd0);
        chk("rst_sb_empty", 64'(exp_q.size()), 64'd0);

        // Sender holds req after ack: exactly one write.
        m = mk(7, 2, 16'h0055, 3);
        exp_q.push_back(m);
        drive(1, m, 1'b1);
        for (int i = 0; i < 10 && !rcv1.ack; i++) step();
        chk("hold_ack", 64'(rcv1.ack), 64'd1);
        flag = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            if (!rcv1.ack) flag = 1'b0;
        end
        chk("hold_ack_stays", 64'(flag), 64'd1);
        drive(1, m, 1'b0);
        step();
        chk("hold_ack_drop", 64'(rcv1.ack), 64'd0);
        wait_drain(50);
        step(6);
        chk("hold_single_write", 64'(dbg_disp0), 64'd1);
        chk("hold_disp1", 64'(dbg_disp1), 64'd7);

        step(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
